// File: rtl/rx_module_pkg.sv
// Shared UART constants, bit-timing helpers and receiver FSM state encoding.
// Also used by the transmit path so both directions agree on the line rate.
package rx_module_pkg;

    localparam int UART_CLK_FREQ = 50_000_000;
    localparam int UART_BAUD     = 9600;

    // Clocks per bit; callers must keep the result >= 4.
    function automatic int bps_cnt(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

    // Mid-bit sample offset.
    function automatic int bps_half(input int clk_freq, input int baud);
        return bps_cnt(clk_freq, baud) / 2;
    endfunction

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_e;

endpackage

// File: rtl/rx_module_bps.sv
// rx_bps_module: bit timer. Counts 0..BPS_CNT-1 and wraps; Count_Clr zeroes it.
// Ports: CLK, RSTn (async low), Count_Clr in; BPS_CLK (mid-bit strobe),
// BPS_END (last cycle of the bit, i.e. wrap) out.
module rx_bps_module
    import rx_module_pkg::*;
#(
    parameter int BPS_CNT  = bps_cnt(UART_CLK_FREQ, UART_BAUD),
    parameter int BPS_HALF = bps_half(UART_CLK_FREQ, UART_BAUD)
) (
    input  logic CLK,
    input  logic RSTn,
    input  logic Count_Clr,
    output logic BPS_CLK,
    output logic BPS_END
);

    localparam int CW = (BPS_CNT > 1) ? $clog2(BPS_CNT) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign BPS_CLK = (cnt_q == CW'(BPS_HALF - 1));
    assign BPS_END = (cnt_q == CW'(BPS_CNT - 1));

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (Count_Clr || BPS_END) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/rx_module.sv
// rx_module: 8N1 UART receiver (LSB first) with 2-flop synchronizer and
// mid-bit sampling. Optional even-parity bit when RX_PARITY_EN is defined.
// Ports: CLK, RSTn (async low), RX_Pin_In (serial, idle high), RX_En_Sig
// (level enable) in; RX_Data (last good byte), RX_Done_Sig, RX_Frame_Err,
// RX_Parity_Err (one-cycle pulses; parity pulse tied 0 without RX_PARITY_EN).
module rx_module
    import rx_module_pkg::*;
#(
    parameter int CLK_FREQ = UART_CLK_FREQ,
    parameter int BAUD     = UART_BAUD
) (
    input  logic       CLK,
    input  logic       RSTn,
    input  logic       RX_Pin_In,
    input  logic       RX_En_Sig,
    output logic [7:0] RX_Data,
    output logic       RX_Done_Sig,
    output logic       RX_Frame_Err,
    output logic       RX_Parity_Err
);

    localparam int BPS_CNT  = bps_cnt(CLK_FREQ, BAUD);
    localparam int BPS_HALF = bps_half(CLK_FREQ, BAUD);

    logic rx_s1_q, rx_s1_d;
    logic rx_s2_q, rx_s2_d;
    logic rx_s3_q, rx_s3_d;
    logic h2l;

    rx_state_e state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic [7:0] shreg_q, shreg_d;
    logic [7:0] data_q, data_d;
    logic       done_q, done_d;
    logic       ferr_q, ferr_d;
`ifdef RX_PARITY_EN
    logic       perr_q, perr_d;
`endif

    logic count_clr;
    logic bps_clk;
    logic bps_end;

    rx_bps_module #(
        .BPS_CNT  (BPS_CNT),
        .BPS_HALF (BPS_HALF)
    ) u_bps (
        .CLK       (CLK),
        .RSTn      (RSTn),
        .Count_Clr (count_clr),
        .BPS_CLK   (bps_clk),
        .BPS_END   (bps_end)
    );

    assign rx_s1_d = RX_Pin_In;
    assign rx_s2_d = rx_s1_q;
    assign rx_s3_d = rx_s2_q;
    assign h2l     = rx_s3_q & ~rx_s2_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        data_d  = data_q;
        done_d  = 1'b0;
        ferr_d  = 1'b0;
`ifdef RX_PARITY_EN
        perr_d  = 1'b0;
`endif
        if (state_q != IDLE && !RX_En_Sig) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (RX_En_Sig && h2l) begin
                        state_d = START;
                    end
                end
                START: begin
                    // Line back high at mid-start: glitch, not a frame.
                    if (bps_clk && rx_s2_q) begin
                        state_d = IDLE;
                    end else if (bps_end) begin
                        state_d = DATA;
                        idx_d   = 3'd0;
                    end
                end
                DATA: begin
                    if (bps_clk) begin
                        shreg_d[idx_q] = rx_s2_q;
                    end
                    if (bps_end) begin
                        if (idx_q == 3'd7) begin
`ifdef RX_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end else begin
                            idx_d = idx_q + 3'd1;
                        end
                    end
                end
`ifdef RX_PARITY_EN
                PARITY: begin
                    if (bps_clk && (rx_s2_q != ^shreg_q)) begin
                        perr_d  = 1'b1;
                        state_d = IDLE;
                    end else if (bps_end) begin
                        state_d = STOP;
                    end
                end
`endif
                STOP: begin
                    // Leave at mid-stop so a start edge right at the
                    // nominal stop end is still caught.
                    if (bps_clk) begin
                        state_d = IDLE;
                        if (rx_s2_q) begin
                            data_d = shreg_q;
                            done_d = 1'b1;
                        end else begin
                            ferr_d = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
        count_clr = (state_d != state_q) || (state_q == IDLE);
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            rx_s1_q <= 1'b1;
            rx_s2_q <= 1'b1;
            rx_s3_q <= 1'b1;
            state_q <= IDLE;
            idx_q   <= 3'd0;
            shreg_q <= 8'h00;
            data_q  <= 8'h00;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            rx_s1_q <= rx_s1_d;
            rx_s2_q <= rx_s2_d;
            rx_s3_q <= rx_s3_d;
            state_q <= state_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            data_q  <= data_d;
            done_q  <= done_d;
            ferr_q  <= ferr_d;
        end
    end

`ifdef RX_PARITY_EN
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            perr_q <= 1'b0;
        end else begin
            perr_q <= perr_d;
        end
    end
    assign RX_Parity_Err = perr_q;
`else
    assign RX_Parity_Err = 1'b0;
`endif

    assign RX_Data      = data_q;
    assign RX_Done_Sig  = done_q;
    assign RX_Frame_Err = ferr_q;

endmodule

// File: tb/tb_rx_module.sv
// Testbench for rx_module: serial frames driven with real-time bit periods,
// outcomes checked against a frame-level reference model.
`timescale 1ns/1ps
module tb_rx_module;

    localparam int CLK_FREQ = 3_200_000;
    localparam int BAUD     = 100_000;
    localparam int B        = CLK_FREQ / BAUD;
    localparam int H        = B / 2;
    localparam int T_CLK    = 10;
    localparam int BIT_NS   = B * T_CLK;
`ifdef RX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    localparam int LAT = 9 * B + H + 3 + (PAR ? B : 0);

    typedef struct packed {
        logic [1:0] kind;
        logic [7:0] data;
    } ev_t;

    logic       CLK = 1'b0;
    logic       RSTn = 1'b0;
    logic       RX_Pin_In = 1'b1;
    logic       RX_En_Sig = 1'b0;
    logic [7:0] RX_Data;
    logic       RX_Done_Sig;
    logic       RX_Frame_Err;
    logic       RX_Parity_Err;

    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   done_cyc = -1;
    int   multi = 0;
    ev_t  ev_q[$];
    logic [7:0] mdl_data = 8'h00;

    rx_module #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD)
    ) dut (
        .CLK           (CLK),
        .RSTn          (RSTn),
        .RX_Pin_In     (RX_Pin_In),
        .RX_En_Sig     (RX_En_Sig),
        .RX_Data       (RX_Data),
        .RX_Done_Sig   (RX_Done_Sig),
        .RX_Frame_Err  (RX_Frame_Err),
        .RX_Parity_Err (RX_Parity_Err)
    );

    always #(T_CLK / 2) CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (RX_Done_Sig) begin
            ev_q.push_back({2'd1, RX_Data});
            done_cyc = cyc;
        end
        if (RX_Frame_Err) ev_q.push_back({2'd2, 8'h00});
        if (RX_Parity_Err) ev_q.push_back({2'd3, 8'h00});
        if (int'(RX_Done_Sig) + int'(RX_Frame_Err) + int'(RX_Parity_Err) > 1)
            multi++;
    end

    function automatic logic good_par(input logic [7:0] b);
        return ($countones(b) % 2) == 1;
    endfunction

    // Frame-level outcome: 1=done(data), 2=frame error, 3=parity error.
    function automatic ev_t model_frame(input logic [7:0] b,
                                        input logic par_bit,
                                        input logic stop_bit);
        if (PAR && (par_bit != good_par(b))) return {2'd3, 8'h00};
        if (!stop_bit) return {2'd2, 8'h00};
        return {2'd1, b};
    endfunction

    task automatic send_frame(input logic [7:0] b, input logic par_bit,
                              input logic stop_bit, input int bit_ns);
        RX_Pin_In = 1'b0;
        #(bit_ns);
        for (int i = 0; i < 8; i++) begin
            RX_Pin_In = b[i];
            #(bit_ns);
        end
        if (PAR) begin
            RX_Pin_In = par_bit;
            #(bit_ns);
        end
        RX_Pin_In = stop_bit;
        #(bit_ns);
        RX_Pin_In = 1'b1;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic test_reset();
        RSTn = 1'b0;
        idle_cycles(3);
        n_checks++;
        if (RX_Data !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_data got=%h exp=00", RX_Data);
        end
        n_checks++;
        if (RX_Done_Sig !== 1'b0 || RX_Frame_Err !== 1'b0 || RX_Parity_Err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_pulses got=%b%b%b exp=000",
                     RX_Done_Sig, RX_Frame_Err, RX_Parity_Err);
        end
        RSTn = 1'b1;
        RX_En_Sig = 1'b1;
        idle_cycles(4);
    endtask

    task automatic test_basic();
        int fall;
        ev_q.delete();
        done_cyc = -1;
        @(negedge CLK);
        fall = cyc;
        send_frame(8'h55, good_par(8'h55), 1'b1, BIT_NS);
        idle_cycles(B);
        mdl_data = 8'h55;
        n_checks++;
        if (ev_q.size() != 1) begin
            n_fail++;
            $display("FAIL basic_count got=%0d exp=1", ev_q.size());
        end
        if (ev_q.size() > 0) begin
            n_checks++;
            if (ev_q[0] !== ev_t'({2'd1, 8'h55})) begin
                n_fail++;
                $display("FAIL basic_event got=%h exp=%h", ev_q[0], {2'd1, 8'h55});
            end
        end
        n_checks++;
        if (RX_Data !== mdl_data) begin
            n_fail++;
            $display("FAIL basic_data got=%h exp=%h", RX_Data, mdl_data);
        end
        n_checks++;
        if (done_cyc - fall < LAT - 1 || done_cyc - fall > LAT + 1) begin
            n_fail++;
            $display("FAIL basic_latency got=%0d exp=%0d+-1", done_cyc - fall, LAT);
        end
    endtask

    task automatic test_frame_err();
        ev_q.delete();
        send_frame(8'hA5, good_par(8'hA5), 1'b0, BIT_NS);
        idle_cycles(2 * B);
        n_checks++;
        if (ev_q.size() != 1) begin
            n_fail++;
            $display("FAIL ferr_count got=%0d exp=1", ev_q.size());
        end
        if (ev_q.size() > 0) begin
            n_checks++;
            if (ev_q[0].kind !== 2'd2) begin
                n_fail++;
                $display("FAIL ferr_kind got=%0d exp=2", ev_q[0].kind);
            end
        end
        n_checks++;
        if (RX_Data !== mdl_data) begin
            n_fail++;
            $display("FAIL ferr_data got=%h exp=%h", RX_Data, mdl_data);
        end
    endtask

    task automatic test_glitch();
        ev_q.delete();
        RX_Pin_In = 1'b0;
        idle_cycles(H - 6);
        RX_Pin_In = 1'b1;
        idle_cycles(2 * B);
        n_checks++;
        if (ev_q.size() != 0) begin
            n_fail++;
            $display("FAIL glitch_pulses got=%0d exp=0", ev_q.size());
        end
        n_checks++;
        if (RX_Data !== mdl_data) begin
            n_fail++;
            $display("FAIL glitch_data got=%h exp=%h", RX_Data, mdl_data);
        end
        send_frame(8'h0F, good_par(8'h0F), 1'b1, BIT_NS);
        idle_cycles(B);
        mdl_data = 8'h0F;
        n_checks++;
        if (ev_q.size() != 1 || RX_Data !== mdl_data) begin
            n_fail++;
            $display("FAIL glitch_recover got=%0d/%h exp=1/%h",
                     ev_q.size(), RX_Data, mdl_data);
        end
    endtask

    task automatic test_back_to_back();
        ev_t exp_q[$];
        ev_q.delete();
        send_frame(8'h00, good_par(8'h00), 1'b1, 314);
        send_frame(8'hFF, good_par(8'hFF), 1'b1, 314);
        idle_cycles(B);
        exp_q.push_back(model_frame(8'h00, good_par(8'h00), 1'b1));
        exp_q.push_back(model_frame(8'hFF, good_par(8'hFF), 1'b1));
        mdl_data = 8'hFF;
        n_checks++;
        if (ev_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL b2b_count got=%0d exp=%0d", ev_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < ev_q.size(); i++) begin
            n_checks++;
            if (ev_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL b2b_event%0d got=%h exp=%h", i, ev_q[i], exp_q[i]);
            end
        end
        n_checks++;
        if (RX_Data !== mdl_data) begin
            n_fail++;
            $display("FAIL b2b_data got=%h exp=%h", RX_Data, mdl_data);
        end
    endtask

    task automatic test_en_drop();
        ev_q.delete();
        fork
            send_frame(8'h3C, good_par(8'h3C), 1'b1, BIT_NS);
            begin
                #(BIT_NS * 5 + BIT_NS / 2);
                RX_En_Sig = 1'b0;
            end
        join
        idle_cycles(B);
        RX_En_Sig = 1'b1;
        idle_cycles(B);
        n_checks++;
        if (ev_q.size() != 0) begin
            n_fail++;
            $display("FAIL endrop_pulses got=%0d exp=0", ev_q.size());
        end
        n_checks++;
        if (RX_Data !== mdl_data) begin
            n_fail++;
            $display("FAIL endrop_data got=%h exp=%h", RX_Data, mdl_data);
        end
    endtask

    task automatic test_rst_mid();
        ev_q.delete();
        fork
            send_frame(8'h81, good_par(8'h81), 1'b1, BIT_NS);
            begin
                #(BIT_NS * 5 + BIT_NS / 2);
                @(negedge CLK);
                #2 RSTn = 1'b0;
                #1;
                n_checks++;
                if (RX_Data !== 8'h00) begin
                    n_fail++;
                    $display("FAIL rstmid_async_data got=%h exp=00", RX_Data);
                end
            end
        join
        idle_cycles(B);
        @(negedge CLK);
        RSTn = 1'b1;
        mdl_data = 8'h00;
        idle_cycles(3);
        send_frame(8'h3C, good_par(8'h3C), 1'b1, BIT_NS);
        idle_cycles(B);
        mdl_data = 8'h3C;
        n_checks++;
        if (ev_q.size() != 1) begin
            n_fail++;
            $display("FAIL rstmid_count got=%0d exp=1", ev_q.size());
        end
        n_checks++;
        if (RX_Data !== mdl_data) begin
            n_fail++;
            $display("FAIL rstmid_data got=%h exp=%h", RX_Data, mdl_data);
        end
    endtask

`ifdef RX_PARITY_EN
    task automatic test_parity();
        ev_q.delete();
        send_frame(8'h07, 1'b0, 1'b1, BIT_NS);
        idle_cycles(B);
        n_checks++;
        if (ev_q.size() != 1 || ev_q[0].kind !== 2'd3) begin
            n_fail++;
            $display("FAIL parity_bad got=%0d evs exp=1 parity err", ev_q.size());
        end
        n_checks++;
        if (RX_Data !== mdl_data) begin
            n_fail++;
            $display("FAIL parity_bad_data got=%h exp=%h", RX_Data, mdl_data);
        end
        ev_q.delete();
        send_frame(8'h07, 1'b1, 1'b1, BIT_NS);
        idle_cycles(B);
        mdl_data = 8'h07;
        n_checks++;
        if (ev_q.size() != 1 || ev_q[0] !== ev_t'({2'd1, 8'h07})) begin
            n_fail++;
            $display("FAIL parity_good got=%0d evs data=%h exp=1 done 07",
                     ev_q.size(), RX_Data);
        end
    endtask
`endif

    task automatic test_random();
        ev_t exp_q[$];
        logic [7:0] b;
        logic sb;
        logic pb;
        int bn;
        int gap;
        ev_q.delete();
        for (int n = 0; n < 20; n++) begin
            b  = 8'($urandom);
            bn = $urandom_range(314, 326);
            sb = ($urandom_range(0, 4) != 0);
            pb = good_par(b);
            if (PAR && $urandom_range(0, 5) == 0) begin
                pb = ~pb;
                sb = 1'b1;
            end
            gap = sb ? $urandom_range(0, 2 * B) : $urandom_range(B, 2 * B);
            send_frame(b, pb, sb, bn);
            exp_q.push_back(model_frame(b, pb, sb));
            if (exp_q[$].kind == 2'd1) mdl_data = b;
            #(gap * T_CLK);
        end
        idle_cycles(2 * B);
        n_checks++;
        if (ev_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL rand_count got=%0d exp=%0d", ev_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < ev_q.size(); i++) begin
            n_checks++;
            if (ev_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL rand_event%0d got=%h exp=%h", i, ev_q[i], exp_q[i]);
            end
        end
        n_checks++;
        if (RX_Data !== mdl_data) begin
            n_fail++;
            $display("FAIL rand_data got=%h exp=%h", RX_Data, mdl_data);
        end
    endtask

    task automatic test_exclusive();
        n_checks++;
        if (multi != 0) begin
            n_fail++;
            $display("FAIL exclusive_pulses got=%0d overlaps exp=0", multi);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_frame_err();
        test_glitch();
        test_back_to_back();
        test_en_drop();
        test_rst_mid();
`ifdef RX_PARITY_EN
        test_parity();
`endif
        test_random();
        test_exclusive();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
